round_judge: RTL and testbench

//  Decides the outcome of each black-vs-white agar round and feeds scorekeeper.

---
 rtl/round_judge.sv | 189 ++++++++++++++++++
 tb/tb_round_judge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/round_judge.sv
// Black-vs-white agar round referee: 3-stage capture pipeline plus round FSM feeding scorekeeper.
// Optional round timeout is built only when ROUND_JUDGE_TIMEOUT_EN is defined.
module round_judge #(
  parameter int unsigned POS_W        = 10,
  parameter int unsigned SIZE_W       = 8,
  parameter int unsigned MARGIN       = 2,
  parameter int unsigned HOLD_FRAMES  = 120,
  parameter int unsigned ROUND_FRAMES = 3600
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              round_start,
  input  logic [POS_W-1:0]  black_x,
  input  logic [POS_W-1:0]  black_y,
  input  logic [POS_W-1:0]  white_x,
  input  logic [POS_W-1:0]  white_y,
  input  logic [SIZE_W-1:0] black_r,
  input  logic [SIZE_W-1:0] white_r,
  output logic              blackwon,
  output logic              whitewon,
  output logic              add,
  output logic              round_active,
  output logic              draw
);

  localparam int unsigned DW      = POS_W + 1;
  localparam int unsigned PW      = 2 * DW;
  localparam int unsigned DSQ_W   = 2 * POS_W + 3;
  localparam int unsigned RSQ_W   = 2 * SIZE_W;
  localparam int unsigned CMP_W   = (DSQ_W > RSQ_W) ? DSQ_W : RSQ_W;
  localparam int unsigned CNT_MAX = (ROUND_FRAMES > HOLD_FRAMES) ? ROUND_FRAMES : HOLD_FRAMES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAYING = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;

  // Pipeline stage registers
  logic                    v0, v1, v2;
  logic signed [DW-1:0]    dx_q, dy_q;
  logic [SIZE_W-1:0]       rmax_q, rdiff0_q, rdiff1_q;
  logic                    big0_q, big1_q, big2_q;
  logic [DSQ_W-1:0]        dsq_q;
  logic [RSQ_W-1:0]        rsq_q;
  logic                    cap_q;

  logic                    accept_c;
  logic signed [PW-1:0]    dx_sq_c, dy_sq_c;
  logic                    capture_c;

  // A tick is evaluated only in PLAYING and only when no earlier tick is in flight
  assign accept_c  = (state == S_PLAYING) && frame_tick && !(v0 || v1 || v2);
  assign dx_sq_c   = PW'(dx_q) * PW'(dx_q);
  assign dy_sq_c   = PW'(dy_q) * PW'(dy_q);
  assign capture_c = v2 && cap_q;

  // Capture test pipeline: S0 deltas/radii, S1 squares, S2 compare
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      v0       <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      rmax_q   <= '0;
      rdiff0_q <= '0;
      rdiff1_q <= '0;
      big0_q   <= 1'b0;
      big1_q   <= 1'b0;
      big2_q   <= 1'b0;
      dsq_q    <= '0;
      rsq_q    <= '0;
      cap_q    <= 1'b0;
    end else if (state != S_PLAYING) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v0 <= accept_c;
      v1 <= v0;
      v2 <= v1;
      if (accept_c) begin
        dx_q     <= DW'(black_x) - DW'(white_x);
        dy_q     <= DW'(black_y) - DW'(white_y);
        big0_q   <= (black_r > white_r);
        rmax_q   <= (black_r > white_r) ? black_r : white_r;
        rdiff0_q <= (black_r > white_r) ? (black_r - white_r) : (white_r - black_r);
      end
      if (v0) begin
        dsq_q    <= DSQ_W'($unsigned(dx_sq_c)) + DSQ_W'($unsigned(dy_sq_c));
        rsq_q    <= RSQ_W'(rmax_q) * RSQ_W'(rmax_q);
        rdiff1_q <= rdiff0_q;
        big1_q   <= big0_q;
      end
      if (v1) begin
        cap_q  <= (CMP_W'(dsq_q) < CMP_W'(rsq_q)) && (rdiff1_q >= SIZE_W'(MARGIN));
        big2_q <= big1_q;
      end
    end
  end

`ifdef ROUND_JUDGE_TIMEOUT_EN
  logic draw_q;
  assign draw = draw_q;
`else
  assign draw = 1'b0;
`endif

  // Round FSM; cnt counts PLAYING frames, then is reused for the HOLD interval
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      blackwon     <= 1'b0;
      whitewon     <= 1'b0;
      add          <= 1'b0;
      round_active <= 1'b0;
`ifdef ROUND_JUDGE_TIMEOUT_EN
      draw_q       <= 1'b0;
`endif
    end else begin
      add <= 1'b0;
      case (state)
        S_IDLE: begin
          if (round_start) begin
            state        <= S_PLAYING;
            round_active <= 1'b1;
            cnt          <= '0;
          end
        end
        S_PLAYING: begin
          if (frame_tick && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
          end
          if (capture_c) begin
            state        <= S_HOLD;
            round_active <= 1'b0;
            cnt          <= '0;
            add          <= 1'b1;
            blackwon     <= big2_q;
            whitewon     <= !big2_q;
          end
`ifdef ROUND_JUDGE_TIMEOUT_EN
          else if (cnt >= CNT_W'(ROUND_FRAMES)) begin
            state        <= S_HOLD;
            round_active <= 1'b0;
            cnt          <= '0;
            if (black_r > white_r) begin
              blackwon <= 1'b1;
              add      <= 1'b1;
            end else if (white_r > black_r) begin
              whitewon <= 1'b1;
              add      <= 1'b1;
            end else begin
              draw_q   <= 1'b1;
            end
          end
`endif
        end
        S_HOLD: begin
          if (frame_tick) begin
            if (cnt >= CNT_W'(HOLD_FRAMES - 1)) begin
              state    <= S_IDLE;
              cnt      <= '0;
              blackwon <= 1'b0;
              whitewon <= 1'b0;
`ifdef ROUND_JUDGE_TIMEOUT_EN
              draw_q   <= 1'b0;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state        <= S_IDLE;
          round_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// Scoreboard bench for round_judge: expected add pulses are queued at tick time and matched by a monitor.
module tb_round_judge;

  logic       Clk;
  logic       Reset_n;
  logic       frame_tick;
  logic       round_start;
  logic [9:0] black_x, black_y, white_x, white_y;
  logic [7:0] black_r, white_r;
  logic       blackwon, whitewon, add, round_active, draw;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    logic        bw;
  } exp_t;
  exp_t sb[$];

  round_judge #(
    .POS_W(10), .SIZE_W(8), .MARGIN(2), .HOLD_FRAMES(120), .ROUND_FRAMES(4)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .round_start(round_start),
    .black_x(black_x), .black_y(black_y), .white_x(white_x), .white_y(white_y),
    .black_r(black_r), .white_r(white_r),
    .blackwon(blackwon), .whitewon(whitewon), .add(add),
    .round_active(round_active), .draw(draw)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Match every add pulse against the oldest queued expectation
  always @(negedge Clk) begin
    exp_t e;
    if (add === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_add", 32'(add), 0);
      end else begin
        e = sb.pop_front();
        check("add_cycle", cyc, e.cyc);
        check("add_black", 32'(blackwon), 32'(e.bw));
        check("add_white", 32'(whitewon), 32'(!e.bw));
        check("add_draw", 32'(draw), 0);
      end
    end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
      check("add_missing", 32'(add), 1);
      void'(sb.pop_front());
    end
  end

  task automatic set_blobs(input int bx, input int by, input int br,
                           input int wx, input int wy, input int wr);
    black_x = 10'(bx); black_y = 10'(by); black_r = 8'(br);
    white_x = 10'(wx); white_y = 10'(wy); white_r = 8'(wr);
  endtask

  task automatic do_tick(input bit exp_add, input bit exp_black, input int gap);
    exp_t e;
    @(posedge Clk); #1;
    frame_tick = 1'b1;
    if (exp_add) begin
      e.cyc = cyc + 4;
      e.bw  = exp_black;
      sb.push_back(e);
    end
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    repeat (gap) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic pulse_start();
    @(posedge Clk); #1;
    round_start = 1'b1;
    @(posedge Clk); #1;
    round_start = 1'b0;
  endtask

  task automatic abort_round();
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic wait_sb();
    repeat (12) @(posedge Clk);
    #1;
    check("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_blackwon"}, 32'(blackwon), 0);
    check({pfx, "_whitewon"}, 32'(whitewon), 0);
    check({pfx, "_add"}, 32'(add), 0);
    check({pfx, "_active"}, 32'(round_active), 0);
    check({pfx, "_draw"}, 32'(draw), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0; frame_tick = 1'b0; round_start = 1'b0;
    set_blobs(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge Clk);
    #1;
    check_idle("reset");
    Reset_n = 1'b1;

    // Black captures white; add four cycles after the tick, result held 120 ticks
    pulse_start();
    check("t2_active", 32'(round_active), 1);
    set_blobs(100, 100, 20, 110, 100, 5);
    do_tick(1, 1, 0);
    wait_sb();
    check("t2_blackwon", 32'(blackwon), 1);
    check("t2_whitewon", 32'(whitewon), 0);
    check("t2_inactive", 32'(round_active), 0);
    pulse_start();
    check("t2_start_in_hold", 32'(round_active), 0);
    repeat (119) do_tick(0, 0, 1);
    check("t2_held", 32'(blackwon), 1);
    do_tick(0, 0, 1);
    check_idle("t2_end");

    // Reset mid-pipeline aborts the round without an add
    pulse_start();
    do_tick(0, 0, 0);
    abort_round();
    check_idle("t1_in_reset");
    Reset_n = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    check_idle("t1_after");

    // Overlap with near-equal radii is not a capture
    pulse_start();
    set_blobs(200, 200, 10, 200, 200, 11);
    do_tick(0, 0, 6);
    do_tick(0, 0, 6);
    check("t3_active", 32'(round_active), 1);
    check("t3_whitewon", 32'(whitewon), 0);
    abort_round();
    Reset_n = 1'b1;

    // Extreme separation must not wrap into a capture; then white captures
    pulse_start();
    set_blobs(1023, 1023, 4, 0, 0, 30);
    do_tick(0, 0, 6);
    check("t4_far_active", 32'(round_active), 1);
    set_blobs(20, 0, 4, 0, 0, 30);
    do_tick(1, 0, 0);
    wait_sb();
    check("t4_whitewon", 32'(whitewon), 1);
    check("t4_blackwon", 32'(blackwon), 0);
    repeat (120) do_tick(0, 0, 1);
    check_idle("t4_end");

    // round_start ignored while playing; second tick inside pipeline window dropped
    pulse_start();
    pulse_start();
    check("t6_still_active", 32'(round_active), 1);
    set_blobs(100, 100, 20, 110, 100, 5);
    do_tick(1, 1, 0);
    do_tick(0, 0, 0);
    wait_sb();
    check("t6_blackwon", 32'(blackwon), 1);
    repeat (120) do_tick(0, 0, 1);
    check_idle("t6_end");

`ifdef ROUND_JUDGE_TIMEOUT_EN
    // Timeout with equal radii is a draw with no add
    pulse_start();
    set_blobs(0, 0, 12, 500, 500, 12);
    repeat (4) do_tick(0, 0, 6);
    check("t5_draw", 32'(draw), 1);
    check("t5_inactive", 32'(round_active), 0);
    check("t5_blackwon", 32'(blackwon), 0);
    check("t5_whitewon", 32'(whitewon), 0);
    repeat (120) do_tick(0, 0, 1);
    check_idle("t5_end");
`endif

    repeat (5) @(posedge Clk);
    #1;
    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
